tri_bbox_scanner: RTL and testbench



---
 rtl/raster_pkg.sv | 37 +++
 rtl/tri_bbox.sv | 51 +++++
 rtl/tri_bbox_scanner.sv | 179 +++++++++++++++++
 tb/tb_tri_bbox_scanner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// raster_pkg
// Shared types and helpers for the rasteriser front end.
//   COORD_W      : width of one coordinate component
//   coord_t      : one unsigned coordinate
//   vertex_t     : packed vertex, index with VX / VY / VZ
//   scan_state_t : scanner FSM states
//   min3 / max3  : unsigned minimum / maximum of three coordinates
package raster_pkg;

  localparam int COORD_W = 9;

  localparam int VX = 2;
  localparam int VY = 1;
  localparam int VZ = 0;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [2:0][COORD_W-1:0] vertex_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BBOX = 2'd1,
    SCAN = 2'd2
  } scan_state_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tri_bbox.sv
// tri_bbox
// Combinational screen-clamped bounding box of one triangle.
// Ports:
//   v1_in, v2_in, v3_in : vertices, [VX]=x, [VY]=y, [VZ]=depth (unsigned)
//   xmin_out, xmax_out  : horizontal extent, xmax clamped to SCREEN_W-1
//   ymin_out, ymax_out  : vertical extent, ymax clamped to SCREEN_H-1
//   empty_out           : box lies entirely off the right or bottom edge
module tri_bbox
  import raster_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic [2:0][COORD_W-1:0] v1_in,
  input  logic [2:0][COORD_W-1:0] v2_in,
  input  logic [2:0][COORD_W-1:0] v3_in,
  output logic [COORD_W-1:0]      xmin_out,
  output logic [COORD_W-1:0]      xmax_out,
  output logic [COORD_W-1:0]      ymin_out,
  output logic [COORD_W-1:0]      ymax_out,
  output logic                    empty_out
);

  localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

  coord_t xmin_raw;
  coord_t xmax_raw;
  coord_t ymin_raw;
  coord_t ymax_raw;

  // Depth plays no part in the box; it is only reduced here so the
  // otherwise idle bits of the vertex ports are visibly accounted for.
  logic depth_unused;
  assign depth_unused = ^{v1_in[VZ], v2_in[VZ], v3_in[VZ]};

  // Coordinates are unsigned, so only the far edges need clamping. A box
  // whose minimum is already past the far edge has nothing on screen.
  always_comb begin
    xmin_raw  = min3(v1_in[VX], v2_in[VX], v3_in[VX]);
    xmax_raw  = max3(v1_in[VX], v2_in[VX], v3_in[VX]);
    ymin_raw  = min3(v1_in[VY], v2_in[VY], v3_in[VY]);
    ymax_raw  = max3(v1_in[VY], v2_in[VY], v3_in[VY]);
    xmin_out  = xmin_raw;
    ymin_out  = ymin_raw;
    xmax_out  = (xmax_raw > X_LAST) ? X_LAST : xmax_raw;
    ymax_out  = (ymax_raw > Y_LAST) ? Y_LAST : ymax_raw;
    empty_out = (xmin_raw > X_LAST) || (ymin_raw > Y_LAST);
  end

endmodule

// File: rtl/tri_bbox_scanner.sv
// tri_bbox_scanner
// Accepts one triangle, finds its clamped bounding box and walks every pixel
// of the box in raster order (y outer, x inner), one pixel per handshake.
// Ports:
//   clk_in, rst_in         : clock, synchronous active-high reset
//   tri_valid_in           : triangle offered on v*_in
//   tri_ready_out          : scanner idle and able to take a triangle
//   v1_in, v2_in, v3_in    : incoming vertices
//   pix_ready_in           : downstream takes the current pixel
//   pix_valid_out          : x_out / y_out / v*_out describe a pixel
//   x_out, y_out           : pixel position
//   v1_out, v2_out, v3_out : latched vertices, stable for the whole scan
//   last_out               : current pixel is the final one of the box
//   busy_out               : scanner is not idle
module tri_bbox_scanner
  import raster_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    tri_valid_in,
  output logic                    tri_ready_out,
  input  logic [2:0][COORD_W-1:0] v1_in,
  input  logic [2:0][COORD_W-1:0] v2_in,
  input  logic [2:0][COORD_W-1:0] v3_in,
  input  logic                    pix_ready_in,
  output logic                    pix_valid_out,
  output logic [COORD_W-1:0]      x_out,
  output logic [COORD_W-1:0]      y_out,
  output logic [2:0][COORD_W-1:0] v1_out,
  output logic [2:0][COORD_W-1:0] v2_out,
  output logic [2:0][COORD_W-1:0] v3_out,
  output logic                    last_out,
  output logic                    busy_out
);

  scan_state_t state_q, state_d;
  vertex_t     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  coord_t      x_q, x_d, y_q, y_d;
  logic        pix_valid_q, pix_valid_d;
  logic        last_q, last_d;
  coord_t      xmin_q, xmin_d, xmax_q, xmax_d;
  coord_t      ymin_q, ymin_d, ymax_q, ymax_d;
  logic        empty_q, empty_d;

  coord_t      bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic        bb_empty;

  tri_bbox #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bbox (
    .v1_in     (v1_q),
    .v2_in     (v2_q),
    .v3_in     (v3_q),
    .xmin_out  (bb_xmin),
    .xmax_out  (bb_xmax),
    .ymin_out  (bb_ymin),
    .ymax_out  (bb_ymax),
    .empty_out (bb_empty)
  );

  // Next-state logic. The box is captured into registers during BBOX so the
  // min/max/clamp tree never sits in front of the scan counters. SCAN opens
  // with one cycle where pix_valid is still low: that cycle either drops an
  // empty box straight back to IDLE or loads the first pixel. Once a pixel
  // is valid, pix_valid only falls again after the final handshake, so a
  // low pix_valid inside SCAN always means "opening cycle".
  always_comb begin
    state_d     = state_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = pix_valid_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    empty_d     = empty_q;

    unique case (state_q)
      IDLE: begin
        if (tri_valid_in) begin
          v1_d    = v1_in;
          v2_d    = v2_in;
          v3_d    = v3_in;
          state_d = BBOX;
        end
      end

      BBOX: begin
        xmin_d  = bb_xmin;
        xmax_d  = bb_xmax;
        ymin_d  = bb_ymin;
        ymax_d  = bb_ymax;
        empty_d = bb_empty;
        state_d = SCAN;
      end

      SCAN: begin
        if (!pix_valid_q) begin
          if (empty_q) begin
            state_d = IDLE;
          end else begin
            x_d         = xmin_q;
            y_d         = ymin_q;
            pix_valid_d = 1'b1;
          end
        end else if (pix_ready_in) begin
          if (x_q < xmax_q) begin
            x_d = x_q + coord_t'(1);
          end else if (y_q < ymax_q) begin
            x_d = xmin_q;
            y_d = y_q + coord_t'(1);
          end else begin
            pix_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        pix_valid_d = 1'b0;
      end
    endcase

    last_d = pix_valid_d && (x_d == xmax_q) && (y_d == ymax_q);
  end

  // State and datapath registers; reset clears everything, which also
  // abandons any scan in progress together with its latched triangle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      v1_q        <= '0;
      v2_q        <= '0;
      v3_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      last_q      <= 1'b0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      last_q      <= last_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      empty_q     <= empty_d;
    end
  end

  assign tri_ready_out = (state_q == IDLE);
  assign busy_out      = (state_q != IDLE);
  assign pix_valid_out = pix_valid_q;
  assign last_out      = last_q;
  assign x_out         = x_q;
  assign y_out         = y_q;
  assign v1_out        = v1_q;
  assign v2_out        = v2_q;
  assign v3_out        = v3_q;

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// tb_tri_bbox_scanner
// Directed bench for tri_bbox_scanner: reset state, accept latency, raster
// walks with and without downstream stalls, single-pixel and screen-edge
// clamped boxes, a fully off-screen triangle and a reset in mid-scan.
module tb_tri_bbox_scanner;

  logic        clk;
  logic        rst_in;
  logic        tri_valid_in;
  logic        tri_ready_out;
  logic [26:0] v1_in, v2_in, v3_in;
  logic        pix_ready_in;
  logic        pix_valid_out;
  logic [8:0]  x_out, y_out;
  logic [26:0] v1_out, v2_out, v3_out;
  logic        last_out;
  logic        busy_out;

  int total = 0;
  int bad   = 0;

  tri_bbox_scanner dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .tri_valid_in  (tri_valid_in),
    .tri_ready_out (tri_ready_out),
    .v1_in         (v1_in),
    .v2_in         (v2_in),
    .v3_in         (v3_in),
    .pix_ready_in  (pix_ready_in),
    .pix_valid_out (pix_valid_out),
    .x_out         (x_out),
    .y_out         (y_out),
    .v1_out        (v1_out),
    .v2_out        (v2_out),
    .v3_out        (v3_out),
    .last_out      (last_out),
    .busy_out      (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] mkv(input int x, input int y, input int z);
    logic [8:0] xs, ys, zs;
    xs = x[8:0];
    ys = y[8:0];
    zs = z[8:0];
    return {xs, ys, zs};
  endfunction

  task automatic stepClk;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer a triangle, then advance to two edges after the accept edge,
  // checking the busy / not-yet-valid window on the way.
  task automatic applyStimulus(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c);
    checkOutput("ready_before_accept", {31'd0, tri_ready_out}, 32'd1);
    v1_in        = a;
    v2_in        = b;
    v3_in        = c;
    tri_valid_in = 1'b1;
    stepClk();
    tri_valid_in = 1'b0;
    v1_in        = '0;
    v2_in        = '0;
    v3_in        = '0;
    checkOutput("busy_n", {31'd0, busy_out}, 32'd1);
    checkOutput("ready_n", {31'd0, tri_ready_out}, 32'd0);
    checkOutput("valid_n", {31'd0, pix_valid_out}, 32'd0);
    stepClk();
    checkOutput("busy_n1", {31'd0, busy_out}, 32'd1);
    checkOutput("valid_n1", {31'd0, pix_valid_out}, 32'd0);
    stepClk();
  endtask

  // Walk the expected raster of a box and compare every displayed pixel.
  // With toggle set, pix_ready_in alternates 1,0,1,0 so holds are checked too.
  task automatic scanBox(input int xmin, input int xmax, input int ymin, input int ymax,
                         input bit toggle);
    int w, n, e, cyc, ex, ey;
    bit hs;
    w   = xmax - xmin + 1;
    n   = w * (ymax - ymin + 1);
    e   = 0;
    cyc = 0;
    while (e < n && cyc < 2 * n + 10) begin
      pix_ready_in = toggle ? ((cyc % 2) == 0) : 1'b1;
      ex = xmin + (e % w);
      ey = ymin + (e / w);
      checkOutput("pix_valid", {31'd0, pix_valid_out}, 32'd1);
      checkOutput("pix_x", {23'd0, x_out}, ex);
      checkOutput("pix_y", {23'd0, y_out}, ey);
      checkOutput("pix_last", {31'd0, last_out}, (ex == xmax && ey == ymax) ? 32'd1 : 32'd0);
      hs = pix_valid_out && pix_ready_in;
      stepClk();
      cyc++;
      if (hs) e++;
    end
    pix_ready_in = 1'b1;
    checkOutput("scan_count", e, n);
    checkOutput("end_valid", {31'd0, pix_valid_out}, 32'd0);
    checkOutput("end_last", {31'd0, last_out}, 32'd0);
    checkOutput("end_ready", {31'd0, tri_ready_out}, 32'd1);
    checkOutput("end_busy", {31'd0, busy_out}, 32'd0);
  endtask

  initial begin
    rst_in       = 1'b1;
    tri_valid_in = 1'b0;
    pix_ready_in = 1'b1;
    v1_in        = '0;
    v2_in        = '0;
    v3_in        = '0;
    stepClk();
    stepClk();

    $display("[TB] reset state");
    checkOutput("rst_ready", {31'd0, tri_ready_out}, 32'd1);
    checkOutput("rst_valid", {31'd0, pix_valid_out}, 32'd0);
    checkOutput("rst_last", {31'd0, last_out}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_out}, 32'd0);
    checkOutput("rst_x", {23'd0, x_out}, 32'd0);
    checkOutput("rst_y", {23'd0, y_out}, 32'd0);
    checkOutput("rst_v1", {5'd0, v1_out}, 32'd0);
    rst_in = 1'b0;
    stepClk();
    checkOutput("idle_busy", {31'd0, busy_out}, 32'd0);

    $display("[TB] triangle 5x5, ready held high");
    applyStimulus(mkv(2, 4, 11), mkv(4, 1, 12), mkv(0, 0, 13));
    checkOutput("v1_latched", {5'd0, v1_out}, {5'd0, mkv(2, 4, 11)});
    checkOutput("v2_latched", {5'd0, v2_out}, {5'd0, mkv(4, 1, 12)});
    checkOutput("v3_latched", {5'd0, v3_out}, {5'd0, mkv(0, 0, 13)});
    scanBox(0, 4, 0, 4, 1'b0);

    $display("[TB] triangle 5x5, ready toggling");
    applyStimulus(mkv(2, 4, 11), mkv(4, 1, 12), mkv(0, 0, 13));
    scanBox(0, 4, 0, 4, 1'b1);

    $display("[TB] coincident vertices");
    applyStimulus(mkv(7, 3, 1), mkv(7, 3, 2), mkv(7, 3, 3));
    scanBox(7, 7, 3, 3, 1'b0);

    $display("[TB] clamped at screen corner");
    applyStimulus(mkv(310, 230, 0), mkv(400, 239, 0), mkv(315, 300, 0));
    scanBox(310, 319, 230, 239, 1'b0);

    $display("[TB] fully off screen");
    applyStimulus(mkv(320, 0, 0), mkv(330, 5, 0), mkv(500, 9, 0));
    checkOutput("empty_valid", {31'd0, pix_valid_out}, 32'd0);
    checkOutput("empty_busy", {31'd0, busy_out}, 32'd0);
    checkOutput("empty_ready", {31'd0, tri_ready_out}, 32'd1);
    stepClk();
    checkOutput("empty_valid_later", {31'd0, pix_valid_out}, 32'd0);

    $display("[TB] reset at tenth pixel");
    applyStimulus(mkv(2, 4, 11), mkv(4, 1, 12), mkv(0, 0, 13));
    pix_ready_in = 1'b1;
    for (int k = 0; k < 9; k++) stepClk();
    checkOutput("tenth_x", {23'd0, x_out}, 32'd4);
    checkOutput("tenth_y", {23'd0, y_out}, 32'd1);
    checkOutput("tenth_valid", {31'd0, pix_valid_out}, 32'd1);
    rst_in = 1'b1;
    stepClk();
    rst_in = 1'b0;
    checkOutput("abort_valid", {31'd0, pix_valid_out}, 32'd0);
    checkOutput("abort_x", {23'd0, x_out}, 32'd0);
    checkOutput("abort_y", {23'd0, y_out}, 32'd0);
    checkOutput("abort_v1", {5'd0, v1_out}, 32'd0);
    checkOutput("abort_ready", {31'd0, tri_ready_out}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy_out}, 32'd0);
    applyStimulus(mkv(5, 6, 9), mkv(6, 6, 9), mkv(5, 7, 9));
    scanBox(5, 6, 6, 7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
